// File: rtl/ndata_serializer.sv
// ndata_serializer
//
// Width-down converter for a normalized ndata stream. One input beat of
// NUM_ELEMENTS lanes is captured in a hold register. It is then emitted as
// consecutive OUT_ELEMENTS-lane chunks, lowest lanes first. Element order,
// partial keep and last are preserved. Trailing chunks that carry no kept
// lanes are skipped, so the output stream is also normalized.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  input beat accepted when in_valid && in_ready
//   in_data    in   NUM_ELEMENTS lanes of data_t, lane 0 in the LSBs
//   in_keep    in   per-lane keep, contiguous low-order prefix
//   in_last    in   end of stream marker
//   out_valid  out  output chunk valid
//   out_ready  in   output chunk accepted when out_valid && out_ready
//   out_data   out  OUT_ELEMENTS lanes of data_t
//   out_keep   out  per-lane keep of the current chunk
//   out_last   out  asserted on the final chunk of a last input beat
module ndata_serializer #(
  parameter type data_t       = logic [31:0],
  parameter int  NUM_ELEMENTS = 8,
  parameter int  OUT_ELEMENTS = 2,
  localparam int DATA_W       = $bits(data_t)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_ELEMENTS*DATA_W-1:0]   in_data,
  input  logic [NUM_ELEMENTS-1:0]          in_keep,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_ELEMENTS*DATA_W-1:0]   out_data,
  output logic [OUT_ELEMENTS-1:0]          out_keep,
  output logic                             out_last
);

  localparam int RATIO = NUM_ELEMENTS / OUT_ELEMENTS;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int OUT_W = OUT_ELEMENTS * DATA_W;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(RATIO - 1);

  if ((NUM_ELEMENTS % OUT_ELEMENTS) != 0) begin : g_ratio_check
    $error("ndata_serializer: NUM_ELEMENTS must be a multiple of OUT_ELEMENTS");
  end

  // Hold register and chunk pointer
  logic [NUM_ELEMENTS*DATA_W-1:0] hold_data_q, hold_data_d;
  logic [NUM_ELEMENTS-1:0]        hold_keep_q, hold_keep_d;
  logic                           hold_last_q, hold_last_d;
  logic                           hold_valid_q, hold_valid_d;
  logic [IDX_W-1:0]               idx_q, idx_d;

  // Per-chunk views of the hold register
  logic [OUT_W-1:0]        chunk_data [RATIO];
  logic [OUT_ELEMENTS-1:0] chunk_keep [RATIO];
  logic [RATIO-1:0]        chunk_any;

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_chunk
    assign chunk_data[gi] = hold_data_q[gi*OUT_W +: OUT_W];
    assign chunk_keep[gi] = hold_keep_q[gi*OUT_ELEMENTS +: OUT_ELEMENTS];
    assign chunk_any[gi]  = |hold_keep_q[gi*OUT_ELEMENTS +: OUT_ELEMENTS];
  end

  // True when no chunk beyond the current one carries a kept lane. Since
  // keep is a prefix, this ends a partial beat early; an all-zero keep
  // makes chunk 0 final so an empty beat still produces exactly one output.
  logic rest_empty;
  always_comb begin
    rest_empty = 1'b1;
    for (int k = 0; k < RATIO; k++) begin
      if (k > int'(idx_q) && chunk_any[k]) begin
        rest_empty = 1'b0;
      end
    end
  end

  logic final_chunk;
  logic in_fire;
  logic out_fire;

  assign final_chunk = (idx_q == IDX_MAX) || rest_empty;

  assign out_valid = hold_valid_q;
  assign out_data  = chunk_data[idx_q];
  assign out_keep  = chunk_keep[idx_q];
  assign out_last  = hold_last_q && final_chunk;

  // Final-chunk pass-through lets the next beat load on the same edge the
  // last chunk leaves, avoiding a bubble between beats.
  assign in_ready = !hold_valid_q || (out_ready && final_chunk);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = hold_valid_q && out_ready;

  always_comb begin
    hold_data_d  = hold_data_q;
    hold_keep_d  = hold_keep_q;
    hold_last_d  = hold_last_q;
    hold_valid_d = hold_valid_q;
    idx_d        = idx_q;
    if (in_fire) begin
      hold_data_d  = in_data;
      hold_keep_d  = in_keep;
      hold_last_d  = in_last;
      hold_valid_d = 1'b1;
      idx_d        = '0;
    end else if (out_fire) begin
      if (final_chunk) begin
        hold_valid_d = 1'b0;
        idx_d        = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_keep_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      idx_q        <= '0;
    end else begin
      hold_keep_q  <= hold_keep_d;
      hold_last_q  <= hold_last_d;
      hold_valid_q <= hold_valid_d;
      idx_q        <= idx_d;
    end
  end

  // Payload is qualified by hold_valid and keep, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
  end

endmodule

// File: tb/tb_ndata_serializer.sv
module tb_ndata_serializer;

  localparam int N  = 8;
  localparam int O  = 2;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      in_keep;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [O*DW-1:0]   out_data;
  logic [O-1:0]      out_keep;
  logic              out_last;

  always #5 clk = ~clk;

  ndata_serializer #(
    .data_t      (logic [31:0]),
    .NUM_ELEMENTS(N),
    .OUT_ELEMENTS(O)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_keep  (in_keep),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_keep (out_keep),
    .out_last (out_last)
  );

  typedef struct {
    logic [O*DW-1:0] data;
    logic [O-1:0]    keep;
    logic            last;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int passed = 0;
  int n_fires = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int cyc = 0;
  int ready_mode = 0;

  task automatic check(input bit ok, input string name, input string msg);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: %s", name, msg);
  endtask

  // Reference model: a beat with p kept lanes yields max(1, ceil(p/O))
  // output chunks taken in lane order; last goes only on the final one.
  task automatic push_expected(input logic [N*DW-1:0] d, input logic [N-1:0] k,
                               input logic l);
    int p;
    int nb;
    beat_t b;
    p  = $countones(k);
    nb = (p + O - 1) / O;
    if (nb == 0) nb = 1;
    for (int c = 0; c < nb; c++) begin
      b.data = d[c*O*DW +: O*DW];
      b.keep = k[c*O +: O];
      b.last = l && (c == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor / scoreboard
  bit              have_prev = 0;
  logic            prev_v, prev_r, prev_l;
  logic [O*DW-1:0] prev_d;
  logic [O-1:0]    prev_k;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 0;
    end else begin
      if (have_prev && prev_v && !prev_r) begin
        check(out_valid && out_data == prev_d && out_keep == prev_k && out_last == prev_l,
              "stall_stable",
              $sformatf("got v=%0b d=%h k=%b l=%b, need v=1 d=%h k=%b l=%b",
                        out_valid, out_data, out_keep, out_last, prev_d, prev_k, prev_l));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat",
                $sformatf("got d=%h k=%b l=%b, need no beat", out_data, out_keep, out_last));
        end else begin
          beat_t e;
          bit ok;
          e  = exp_q.pop_front();
          ok = (out_keep == e.keep) && (out_last == e.last);
          for (int i = 0; i < O; i++) begin
            if (e.keep[i] && (out_data[i*DW +: DW] !== e.data[i*DW +: DW])) ok = 0;
          end
          check(ok, "beat",
                $sformatf("got d=%h k=%b l=%b, need d=%h k=%b l=%b",
                          out_data, out_keep, out_last, e.data, e.keep, e.last));
        end
        n_fires++;
        if (n_fires == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (in_valid && in_ready) push_expected(in_data, in_keep, in_last);
      have_prev = 1;
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
      prev_k = out_keep;
      prev_l = out_last;
    end
  end

  // out_ready driver: 0 = always, 1 = random, 2 = pattern 1,0,0,1,0,1
  initial begin
    int pat_i;
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pat_i = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2: begin
          out_ready = pat[pat_i % 6];
          pat_i++;
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_beat(input logic [N*DW-1:0] d, input logic [N-1:0] k,
                           input logic l);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        check(1'b0, "in_ready_timeout", "got no in_ready in 200 cycles, need handshake");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(exp_q.size() == 0 && !out_valid, "drain",
          $sformatf("got %0d pending beats, out_valid=%0b, need 0 and 0", exp_q.size(), out_valid));
  endtask

  function automatic logic [N*DW-1:0] seq_data(input int base);
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(base + i);
    return d;
  endfunction

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = $urandom;
    return d;
  endfunction

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_keep  = '0;
    in_last  = 1'b0;
    #12;
    check(!out_valid && !out_last && in_ready, "reset_state",
          $sformatf("got v=%0b l=%0b rdy=%0b, need 0 0 1", out_valid, out_last, in_ready));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check(in_ready && !out_valid, "after_reset",
          $sformatf("got rdy=%0b v=%0b, need 1 0", in_ready, out_valid));

    // Full non-last beat: four chunks, 1-cycle latency
    ready_mode = 0;
    send_beat(seq_data(0), 8'hFF, 1'b0);
    check(out_valid && out_data == {32'd1, 32'd0} && !in_ready, "latency",
          $sformatf("got v=%0b d=%h rdy=%0b, need v=1 d={1,0} rdy=0", out_valid, out_data, in_ready));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check(out_data == {32'd7, 32'd6} && out_keep == 2'b11 && !out_last && in_ready, "fourth_chunk",
          $sformatf("got d=%h k=%b l=%b rdy=%0b, need {7,6} 11 0 1", out_data, out_keep, out_last, in_ready));
    drain();

    // Partial last beat: chunks 2-3 skipped
    send_beat(seq_data(0), 8'b0000_0111, 1'b1);
    @(posedge clk);
    #1;
    check(out_keep == 2'b01 && out_last && in_ready, "partial_final",
          $sformatf("got k=%b l=%b rdy=%0b, need 01 1 1", out_keep, out_last, in_ready));
    drain();

    // Full last beat, then empty last beat
    send_beat(seq_data(0), 8'hFF, 1'b1);
    drain();
    n_fires = 0;
    send_beat(seq_data(0), 8'h00, 1'b1);
    drain();
    check(n_fires == 1, "empty_last_count", $sformatf("got %0d beats, need 1", n_fires));

    // Three back-to-back beats without a bubble
    n_fires = 0;
    send_beat(seq_data(0), 8'hFF, 1'b0);
    send_beat(seq_data(0), 8'hFF, 1'b0);
    send_beat(seq_data(0), 8'hFF, 1'b1);
    drain();
    check(n_fires == 12 && (last_cyc - first_cyc) == 11, "no_bubble",
          $sformatf("got %0d beats over %0d cycles, need 12 over 11", n_fires, last_cyc - first_cyc));

    // Stall pattern
    ready_mode = 2;
    for (int b = 0; b < 4; b++) send_beat(seq_data(b * 8), 8'hFF, b == 3);
    drain();

    // Randomized traffic with random backpressure and partial last beats
    ready_mode = 1;
    for (int b = 0; b < 60; b++) begin
      logic l;
      logic [N-1:0] k;
      int len;
      l = ($urandom_range(0, 3) == 0);
      if (l) begin
        len = $urandom_range(0, N);
        k = N'((1 << len) - 1);
      end else begin
        k = '1;
      end
      send_beat(rand_data(), k, l);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    // Reset while idx = 2
    ready_mode = 0;
    send_beat(seq_data(0), 8'hFF, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check(out_valid && out_data == {32'd5, 32'd4}, "pre_reset_idx2",
          $sformatf("got v=%0b d=%h, need 1 {5,4}", out_valid, out_data));
    rst_n = 1'b0;
    #1;
    check(!out_valid && !out_last && in_ready, "reset_async",
          $sformatf("got v=%0b l=%0b rdy=%0b, need 0 0 1", out_valid, out_last, in_ready));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check(in_ready && !out_valid, "reset_release",
          $sformatf("got rdy=%0b v=%0b, need 1 0", in_ready, out_valid));
    send_beat(seq_data(100), 8'hFF, 1'b1);
    check(out_valid && out_data == {32'd101, 32'd100}, "restart_chunk0",
          $sformatf("got v=%0b d=%h, need 1 {101,100}", out_valid, out_data));
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
